// File: rtl/tt_spine_ctrl.sv
// Spine-side controller: owns the design-select index and enable strobe, and
// changes the select only through a break-before-make enable sequence.
module tt_spine_ctrl #(
  parameter int N_IO    = 8,
  parameter int N_O     = 8,
  parameter int N_I     = 10,
  parameter int SEL_MAX = 1023,
  parameter int GUARD   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sel_rst,
  input  logic                      sel_inc,
  input  logic                      ena_req,
  input  logic [N_I+N_IO-1:0]       usr_in,
  output logic [N_O+2*N_IO-1:0]     usr_out,
  output logic [N_I+N_IO+12:0]      spine_iw,
  input  logic [N_O+2*N_IO+1:0]     spine_ow,
  output logic [9:0]                sel_cur,
  output logic                      busy
);

  localparam int W_UO = N_O + 2*N_IO;

  typedef enum logic [1:0] {
    S_RUN = 2'd0,
    S_OFF = 2'd1,
    S_UPD = 2'd2,
    S_ON  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_sync_rst;
  logic [1:0]  r_sync_inc;
  logic [1:0]  r_sync_ena;
  logic        r_prev_rst;
  logic        r_prev_inc;
  logic [3:0]  r_pend;
  logic        r_rst_req;
  logic [3:0]  r_guard;
  logic [9:0]  r_sel;
  logic        r_ena;
  logic        r_busy;

  logic        w_rst_edge;
  logic        w_inc_edge;
  logic        w_req;
  logic        w_run_ok;
  logic        w_guard_done;
  logic [3:0]  w_guard_nxt;
  logic        w_pend_dec;
  logic [3:0]  w_pend_tmp;
  logic [3:0]  w_pend_nxt;
  logic        w_rst_req_nxt;
  logic [9:0]  w_sel_nxt;
  logic        w_unused_guards;

  assign w_rst_edge   = r_sync_rst[1] & ~r_prev_rst;
  assign w_inc_edge   = r_sync_inc[1] & ~r_prev_inc;
  assign w_req        = r_rst_req | (r_pend != 4'd0);
  assign w_guard_done = (r_guard == 4'(GUARD - 1));

  // Pad synchronizers and edge history.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync_rst <= 2'b00;
      r_sync_inc <= 2'b00;
      r_sync_ena <= 2'b00;
      r_prev_rst <= 1'b0;
      r_prev_inc <= 1'b0;
    end else begin
      r_sync_rst <= {r_sync_rst[0], sel_rst};
      r_sync_inc <= {r_sync_inc[0], sel_inc};
      r_sync_ena <= {r_sync_ena[0], ena_req};
      r_prev_rst <= r_sync_rst[1];
      r_prev_inc <= r_sync_inc[1];
    end
  end

  // Next-state and guard counter; the enable may only follow the pad in an undisturbed RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_guard_nxt = r_guard;
    w_run_ok    = 1'b0;
    case (r_state)
      S_RUN: begin
        if (w_req) begin
          w_state_nxt = S_OFF;
          w_guard_nxt = 4'd0;
        end else begin
          w_run_ok = 1'b1;
        end
      end
      S_OFF: begin
        if (w_guard_done) begin
          w_state_nxt = S_UPD;
          w_guard_nxt = 4'd0;
        end else begin
          w_guard_nxt = r_guard + 4'd1;
        end
      end
      S_UPD: begin
        w_state_nxt = S_ON;
        w_guard_nxt = 4'd0;
      end
      S_ON: begin
        if (w_guard_done) begin
          w_guard_nxt = 4'd0;
          w_state_nxt = w_req ? S_UPD : S_RUN;
        end else begin
          w_guard_nxt = r_guard + 4'd1;
        end
      end
      default: begin
        w_state_nxt = S_RUN;
        w_guard_nxt = 4'd0;
      end
    endcase
  end

  // Request bookkeeping and select update; a reset edge outranks a same-cycle increment or UPD.
  always_comb begin
    w_pend_dec    = (r_state == S_UPD) & ~r_rst_req;
    w_pend_tmp    = r_pend - {3'd0, w_pend_dec};
    w_pend_nxt    = w_pend_tmp;
    w_rst_req_nxt = r_rst_req;
    w_sel_nxt     = r_sel;
    if (w_rst_edge) begin
      w_pend_nxt = 4'd0;
    end else if (w_inc_edge && (w_pend_tmp != 4'd15)) begin
      w_pend_nxt = w_pend_tmp + 4'd1;
    end else begin
      w_pend_nxt = w_pend_tmp;
    end
    if (w_rst_edge) begin
      w_rst_req_nxt = 1'b1;
    end else if (r_state == S_UPD) begin
      w_rst_req_nxt = 1'b0;
    end else begin
      w_rst_req_nxt = r_rst_req;
    end
    if (r_state == S_UPD) begin
      if (r_rst_req || (r_sel == 10'(SEL_MAX))) begin
        w_sel_nxt = 10'd0;
      end else begin
        w_sel_nxt = r_sel + 10'd1;
      end
    end else begin
      w_sel_nxt = r_sel;
    end
  end

  // Controller state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_RUN;
      r_guard   <= 4'd0;
      r_pend    <= 4'd0;
      r_rst_req <= 1'b0;
      r_sel     <= 10'd0;
      r_ena     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_guard   <= w_guard_nxt;
      r_pend    <= w_pend_nxt;
      r_rst_req <= w_rst_req_nxt;
      r_sel     <= w_sel_nxt;
      r_ena     <= w_run_ok & r_sync_ena[1];
      r_busy    <= ~w_run_ok;
    end
  end

  assign w_unused_guards = spine_ow[W_UO+1] ^ spine_ow[0];
  assign usr_out  = spine_ow[W_UO:1];
  assign spine_iw = {1'b0, usr_in, r_sel, r_ena, 1'b0};
  assign sel_cur  = r_sel;
  assign busy     = r_busy;

endmodule

// File: tb/tb_tt_spine_ctrl.sv
// Directed bench for tt_spine_ctrl: a per-cycle vector table for one increment,
// then hand-written sequences on a default instance and a SEL_MAX=5/GUARD=15 instance.
module tb_tt_spine_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // instance A: default parameters
  logic        rst_a, sel_rst_a, sel_inc_a, ena_req_a;
  logic [17:0] usr_in_a;
  logic [23:0] usr_out_a;
  logic [30:0] spine_iw_a;
  logic [25:0] spine_ow_a;
  logic [9:0]  sel_a;
  logic        busy_a;

  // instance B: small select range, long guard
  logic        rst_b, sel_rst_b, sel_inc_b, ena_req_b;
  logic [17:0] usr_in_b;
  logic [23:0] usr_out_b;
  logic [30:0] spine_iw_b;
  logic [25:0] spine_ow_b;
  logic [9:0]  sel_b;
  logic        busy_b;

  tt_spine_ctrl dut_a (
    .clk(clk), .rst(rst_a), .sel_rst(sel_rst_a), .sel_inc(sel_inc_a),
    .ena_req(ena_req_a), .usr_in(usr_in_a), .usr_out(usr_out_a),
    .spine_iw(spine_iw_a), .spine_ow(spine_ow_a), .sel_cur(sel_a), .busy(busy_a)
  );

  tt_spine_ctrl #(.SEL_MAX(5), .GUARD(15)) dut_b (
    .clk(clk), .rst(rst_b), .sel_rst(sel_rst_b), .sel_inc(sel_inc_b),
    .ena_req(ena_req_b), .usr_in(usr_in_b), .usr_out(usr_out_b),
    .spine_iw(spine_iw_b), .spine_ow(spine_ow_b), .sel_cur(sel_b), .busy(busy_b)
  );

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        ena_req;
    logic        inc;
    logic [17:0] usr;
    logic [25:0] ow;
    logic        exp_ena;
    logic [9:0]  exp_sel;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[15];

  // B select-change monitor, sampled on the falling edge
  int          b_changes = 0;
  int          b_saw5 = 0;
  logic [9:0]  b_prev = 10'd0;
  always @(negedge clk) begin
    if (sel_b != b_prev) b_changes <= b_changes + 1;
    if (sel_b == 10'd5)  b_saw5 <= b_saw5 + 1;
    b_prev <= sel_b;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setv(input int i, input logic er, input logic inc,
                      input logic e, input logic [9:0] s, input logic b);
    vecs[i].ena_req  = er;
    vecs[i].inc      = inc;
    vecs[i].usr      = 18'h2A5A5 ^ (18'(i) * 18'h01111);
    vecs[i].ow       = 26'h15A3C5E ^ (26'(i) * 26'h0123457);
    vecs[i].exp_ena  = e;
    vecs[i].exp_sel  = s;
    vecs[i].exp_busy = b;
  endtask

  initial begin
    int          c0, s0, rises, ok;
    logic        pe;
    logic [9:0]  ps;
    logic [30:0] exp_iw;

    rst_a = 1'b1; sel_rst_a = 1'b0; sel_inc_a = 1'b0; ena_req_a = 1'b0;
    usr_in_a = 18'd0; spine_ow_a = 26'd0;
    rst_b = 1'b1; sel_rst_b = 1'b0; sel_inc_b = 1'b0; ena_req_b = 1'b1;
    usr_in_b = 18'd0; spine_ow_b = 26'd0;

    // row i = inputs before edge i+1 after reset release, expected after that edge
    setv( 0, 1'b1, 1'b0, 1'b0, 10'd0, 1'b0);
    setv( 1, 1'b1, 1'b0, 1'b0, 10'd0, 1'b0);
    setv( 2, 1'b1, 1'b0, 1'b1, 10'd0, 1'b0);
    setv( 3, 1'b1, 1'b0, 1'b1, 10'd0, 1'b0);
    setv( 4, 1'b1, 1'b1, 1'b1, 10'd0, 1'b0);
    setv( 5, 1'b1, 1'b0, 1'b1, 10'd0, 1'b0);
    setv( 6, 1'b1, 1'b0, 1'b1, 10'd0, 1'b0);
    setv( 7, 1'b1, 1'b0, 1'b0, 10'd0, 1'b1);
    setv( 8, 1'b0, 1'b0, 1'b0, 10'd0, 1'b1);
    setv( 9, 1'b1, 1'b0, 1'b0, 10'd0, 1'b1);
    setv(10, 1'b1, 1'b0, 1'b0, 10'd1, 1'b1);
    setv(11, 1'b1, 1'b0, 1'b0, 10'd1, 1'b1);
    setv(12, 1'b1, 1'b0, 1'b0, 10'd1, 1'b1);
    setv(13, 1'b1, 1'b0, 1'b1, 10'd1, 1'b0);
    setv(14, 1'b1, 1'b0, 1'b1, 10'd1, 1'b0);

    repeat (3) tick();
    chk("reset_ena", {31'd0, spine_iw_a[1]}, 32'd0);
    chk("reset_sel", {22'd0, sel_a}, 32'd0);
    chk("reset_busy", {31'd0, busy_a}, 32'd0);
    rst_a = 1'b0;

    // single increment, GUARD=2: six enable-low cycles with the select change in the fourth
    for (int i = 0; i < 15; i++) begin
      ena_req_a  = vecs[i].ena_req;
      sel_inc_a  = vecs[i].inc;
      usr_in_a   = vecs[i].usr;
      spine_ow_a = vecs[i].ow;
      tick();
      exp_iw = {1'b0, vecs[i].usr, vecs[i].exp_sel, vecs[i].exp_ena, 1'b0};
      chk($sformatf("vec%0d_spine_iw", i), {1'b0, spine_iw_a}, {1'b0, exp_iw});
      chk($sformatf("vec%0d_sel", i), {22'd0, sel_a}, {22'd0, vecs[i].exp_sel});
      chk($sformatf("vec%0d_busy", i), {31'd0, busy_a}, {31'd0, vecs[i].exp_busy});
      chk($sformatf("vec%0d_usr_out", i), {8'd0, usr_out_a}, {8'd0, vecs[i].ow[24:1]});
    end

    // three increments four cycles apart: select 1 -> 4, enable rises once, after the last change
    rises = 0; pe = spine_iw_a[1]; ps = sel_a;
    for (int i = 0; i < 30; i++) begin
      sel_inc_a = (i == 0 || i == 4 || i == 8) ? 1'b1 : 1'b0;
      tick();
      if (sel_a != ps) chk("three_sel_change_ena_low", {30'd0, pe, spine_iw_a[1]}, 32'd0);
      if (spine_iw_a[1] && !pe) begin
        rises++;
        chk("three_ena_rise_sel", {22'd0, sel_a}, 32'd4);
      end
      pe = spine_iw_a[1]; ps = sel_a;
    end
    chk("three_rises", rises, 32'd1);
    chk("three_final_sel", {22'd0, sel_a}, 32'd4);
    chk("three_final_busy", {31'd0, busy_a}, 32'd0);

    // three queued increments, sel_rst during the first ON drops the queue
    for (int i = 0; i < 6; i++) begin
      sel_inc_a = (i == 0 || i == 2 || i == 4) ? 1'b1 : 1'b0;
      tick();
    end
    ok = 0;
    for (int i = 0; i < 40 && ok == 0; i++) begin
      if (sel_a == 10'd5) ok = 1; else tick();
    end
    chk("rstq_first_change_seen", ok, 32'd1);
    sel_rst_a = 1'b1; tick(); sel_rst_a = 1'b0;
    repeat (3) tick();
    ok = 0;
    for (int i = 0; i < 60 && ok == 0; i++) begin
      if (!busy_a) ok = 1; else tick();
    end
    chk("rstq_idle_reached", ok, 32'd1);
    chk("rstq_final_sel", {22'd0, sel_a}, 32'd0);
    tick();
    chk("rstq_ena_back", {31'd0, spine_iw_a[1]}, 32'd1);

    // rst in the middle of a sequence (sel already changed, state ON)
    sel_inc_a = 1'b1; tick(); sel_inc_a = 1'b0;
    repeat (7) tick();
    chk("mid_sel_before_rst", {22'd0, sel_a}, 32'd1);
    rst_a = 1'b1; tick(); rst_a = 1'b0;
    chk("mid_rst_ena", {31'd0, spine_iw_a[1]}, 32'd0);
    chk("mid_rst_sel", {22'd0, sel_a}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy_a}, 32'd0);
    repeat (20) tick();
    chk("mid_rst_no_leftover", {21'd0, busy_a, sel_a}, 32'd0);

    // B: six increments with SEL_MAX=5 walk 0..5 and wrap back to 0
    rst_b = 1'b0;
    repeat (5) tick();
    c0 = b_changes; s0 = b_saw5;
    for (int j = 0; j < 6; j++) begin
      sel_inc_b = 1'b1; tick(); sel_inc_b = 1'b0; tick();
    end
    ok = 0;
    for (int i = 0; i < 2000 && ok == 0; i++) begin
      if (!busy_b) ok = 1; else tick();
    end
    tick();
    chk("wrap_idle_reached", ok, 32'd1);
    chk("wrap_final_sel", {22'd0, sel_b}, 32'd0);
    chk("wrap_changes", b_changes - c0, 32'd6);
    chk("wrap_saw_max", {31'd0, (b_saw5 - s0) > 0}, 32'd1);

    // B: 20 edges two cycles apart; pend saturates, 17 passes in total with GUARD=15
    // (two passes complete while edges still arrive, then a saturated queue of 15)
    rst_b = 1'b1; tick(); rst_b = 1'b0;
    repeat (5) tick();
    c0 = b_changes;
    for (int j = 0; j < 20; j++) begin
      sel_inc_b = 1'b1; tick(); sel_inc_b = 1'b0; tick();
    end
    ok = 0;
    for (int i = 0; i < 2000 && ok == 0; i++) begin
      if (!busy_b) ok = 1; else tick();
    end
    tick();
    chk("sat_idle_reached", ok, 32'd1);
    chk("sat_changes", b_changes - c0, 32'd17);
    chk("sat_final_sel", {22'd0, sel_b}, 32'd5);
    chk("sat_ena_back", {31'd0, spine_iw_b[1]}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
